// File: rtl/ama_riscv_pkg.sv
// Shared definitions for the register-file write-back path: requester indices,
// widths, the write-request struct and a one-hot register decoder.
package ama_riscv_pkg;

  localparam int REQ_PIPE = 0;
  localparam int REQ_LSU  = 1;
  localparam int REQ_MDU  = 2;
  localparam int REQ_NUM  = 3;

  localparam int RF_AW  = 5;
  localparam int XLEN   = 32;
  localparam int RF_NUM = 2 ** RF_AW;

  // Round-robin pointer encoding for the two secondary sources
  localparam logic RR_LSU = 1'b0;
  localparam logic RR_MDU = 1'b1;

  typedef struct packed {
    logic [RF_AW-1:0] rd;
    logic [XLEN-1:0]  data;
  } wb_req_t;

  function automatic logic [RF_NUM-1:0] rd_onehot(input logic [RF_AW-1:0] rd);
    return RF_NUM'(1) << rd;
  endfunction

endpackage

// File: rtl/ama_riscv_rf_wb_arbiter_if.sv
// Write-back request bundle for the three register-file writers.
// master = requester side, slave = arbiter side.
interface ama_riscv_rf_wb_arbiter_if;
  import ama_riscv_pkg::*;

  logic             pipe_valid;
  logic             pipe_ready;
  logic [RF_AW-1:0] pipe_rd;
  logic [XLEN-1:0]  pipe_data;

  logic             lsu_valid;
  logic             lsu_ready;
  logic [RF_AW-1:0] lsu_rd;
  logic [XLEN-1:0]  lsu_data;

  logic             mdu_valid;
  logic             mdu_ready;
  logic [RF_AW-1:0] mdu_rd;
  logic [XLEN-1:0]  mdu_data;

  modport master (
    output pipe_valid, pipe_rd, pipe_data,
    output lsu_valid,  lsu_rd,  lsu_data,
    output mdu_valid,  mdu_rd,  mdu_data,
    input  pipe_ready, lsu_ready, mdu_ready
  );

  modport slave (
    input  pipe_valid, pipe_rd, pipe_data,
    input  lsu_valid,  lsu_rd,  lsu_data,
    input  mdu_valid,  mdu_rd,  mdu_data,
    output pipe_ready, lsu_ready, mdu_ready
  );

endinterface

// File: rtl/ama_riscv_rf_scoreboard.sv
// Pending-destination scoreboard: flags decode sources that still await an
// LSU/MDU write-back. Built only when AMA_RISCV_RF_SCOREBOARD_EN is defined.
module ama_riscv_rf_scoreboard
  import ama_riscv_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_set_valid,
  input  logic [RF_AW-1:0] i_set_rd,
  input  logic             i_clr_valid,
  input  logic [RF_AW-1:0] i_clr_rd,
  input  logic [RF_AW-1:0] i_rd_addr_a,
  input  logic [RF_AW-1:0] i_rd_addr_b,
  output logic             o_hazard_stall
);

  logic [RF_NUM-1:0] r_pending;
  logic [RF_NUM-1:0] w_setMask;
  logic [RF_NUM-1:0] w_clrMask;
  logic [RF_NUM-1:0] w_pendingNext;

  // Set is applied after clear so a same-cycle re-issue keeps the bit pending
  always_comb begin
    w_setMask        = i_set_valid ? rd_onehot(i_set_rd) : '0;
    w_clrMask        = i_clr_valid ? rd_onehot(i_clr_rd) : '0;
    w_pendingNext    = (r_pending & ~w_clrMask) | w_setMask;
    w_pendingNext[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pending <= '0;
    end else begin
      r_pending <= w_pendingNext;
    end
  end

  assign o_hazard_stall = r_pending[i_rd_addr_a] | r_pending[i_rd_addr_b];

endmodule

// File: rtl/ama_riscv_rf_wb_arbiter.sv
// Register-file write-port arbiter: pipeline first, LSU/MDU round-robin with a
// starvation guard, registered write. Optional scoreboard: AMA_RISCV_RF_SCOREBOARD_EN.
module ama_riscv_rf_wb_arbiter
  import ama_riscv_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
)(
  input  logic                       clk,
  input  logic                       rst_n,
  ama_riscv_rf_wb_arbiter_if.slave   wb,
  output logic                       o_rf_we,
  output logic [RF_AW-1:0]           o_rf_addr_d,
  output logic [XLEN-1:0]            o_rf_data_d,
  input  logic                       i_issue_valid,
  input  logic [RF_AW-1:0]           i_issue_rd,
  input  logic [RF_AW-1:0]           i_rd_addr_a,
  input  logic [RF_AW-1:0]           i_rd_addr_b,
  output logic                       o_hazard_stall
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  logic               r_rrPtr;
  logic [3:0]         r_starveCnt;
  logic               w_secReq;
  logic               w_force;
  logic               w_lsuPick;
  logic               w_mduPick;
  logic [REQ_NUM-1:0] w_grant;
  logic               w_secGrant;
  logic               w_anyGrant;
  wb_req_t            w_win;

  // Grants are gated by rst_n so no requester sees ready while in reset
  always_comb begin
    w_secReq  = wb.lsu_valid | wb.mdu_valid;
    w_force   = w_secReq && (r_starveCnt == LIMIT);
    w_lsuPick = wb.lsu_valid && ((r_rrPtr == RR_LSU) || !wb.mdu_valid);
    w_mduPick = wb.mdu_valid && ((r_rrPtr == RR_MDU) || !wb.lsu_valid);
    w_grant   = '0;
    if (rst_n) begin
      if (wb.pipe_valid && !w_force) begin
        w_grant[REQ_PIPE] = 1'b1;
      end else if (w_lsuPick) begin
        w_grant[REQ_LSU] = 1'b1;
      end else if (w_mduPick) begin
        w_grant[REQ_MDU] = 1'b1;
      end
    end
  end

  assign wb.pipe_ready = w_grant[REQ_PIPE];
  assign wb.lsu_ready  = w_grant[REQ_LSU];
  assign wb.mdu_ready  = w_grant[REQ_MDU];
  assign w_secGrant    = w_grant[REQ_LSU] | w_grant[REQ_MDU];
  assign w_anyGrant    = |w_grant;

  always_comb begin
    w_win = '{rd: wb.pipe_rd, data: wb.pipe_data};
    if (w_grant[REQ_LSU]) begin
      w_win = '{rd: wb.lsu_rd, data: wb.lsu_data};
    end else if (w_grant[REQ_MDU]) begin
      w_win = '{rd: wb.mdu_rd, data: wb.mdu_data};
    end
  end

  // x0 writes are accepted but never reach the register file
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_rf_we     <= 1'b0;
      o_rf_addr_d <= '0;
      o_rf_data_d <= '0;
    end else if (w_anyGrant) begin
      o_rf_we     <= (w_win.rd != '0);
      o_rf_addr_d <= w_win.rd;
      o_rf_data_d <= w_win.data;
    end else begin
      o_rf_we     <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rrPtr     <= RR_LSU;
      r_starveCnt <= '0;
    end else if (w_secGrant) begin
      r_rrPtr     <= w_grant[REQ_LSU] ? RR_MDU : RR_LSU;
      r_starveCnt <= '0;
    end else if (w_secReq && (r_starveCnt != 4'hF)) begin
      r_starveCnt <= r_starveCnt + 4'd1;
    end
  end

`ifdef AMA_RISCV_RF_SCOREBOARD_EN
  ama_riscv_rf_scoreboard u_scoreboard (
    .clk            (clk),
    .rst_n          (rst_n),
    .i_set_valid    (i_issue_valid && (i_issue_rd != '0)),
    .i_set_rd       (i_issue_rd),
    .i_clr_valid    (w_secGrant),
    .i_clr_rd       (w_win.rd),
    .i_rd_addr_a    (i_rd_addr_a),
    .i_rd_addr_b    (i_rd_addr_b),
    .o_hazard_stall (o_hazard_stall)
  );
`else
  logic w_unused_sb;
  assign w_unused_sb    = ^{i_issue_valid, i_issue_rd, i_rd_addr_a, i_rd_addr_b};
  assign o_hazard_stall = 1'b0;
`endif

endmodule

// File: tb/tb_ama_riscv_rf_wb_arbiter.sv
// Directed bench for ama_riscv_rf_wb_arbiter; scoreboard steps are exercised
// when AMA_RISCV_RF_SCOREBOARD_EN is defined.
module tb_ama_riscv_rf_wb_arbiter;
  import ama_riscv_pkg::*;

  logic             clk;
  logic             rst_n;
  logic             rfWe;
  logic [RF_AW-1:0] rfAddrD;
  logic [XLEN-1:0]  rfDataD;
  logic             issueValid;
  logic [RF_AW-1:0] issueRd;
  logic [RF_AW-1:0] rdAddrA;
  logic [RF_AW-1:0] rdAddrB;
  logic             hazardStall;
  int               compared;
  int               mismatched;

  ama_riscv_rf_wb_arbiter_if wbIf ();

  ama_riscv_rf_wb_arbiter #(.STARVE_LIMIT(4)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .wb             (wbIf),
    .o_rf_we        (rfWe),
    .o_rf_addr_d    (rfAddrD),
    .o_rf_data_d    (rfDataD),
    .i_issue_valid  (issueValid),
    .i_issue_rd     (issueRd),
    .i_rd_addr_a    (rdAddrA),
    .i_rd_addr_b    (rdAddrB),
    .o_hazard_stall (hazardStall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic pv, input logic [4:0] prd, input logic [31:0] pdata,
                               input logic lv, input logic [4:0] lrd, input logic [31:0] ldata,
                               input logic mv, input logic [4:0] mrd, input logic [31:0] mdata);
    wbIf.pipe_valid = pv; wbIf.pipe_rd = prd; wbIf.pipe_data = pdata;
    wbIf.lsu_valid  = lv; wbIf.lsu_rd  = lrd; wbIf.lsu_data  = ldata;
    wbIf.mdu_valid  = mv; wbIf.mdu_rd  = mrd; wbIf.mdu_data  = mdata;
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic checkReady(input string tag, input logic p, input logic l, input logic m);
    #1;
    checkOutput({tag, "_pipe_ready"}, 32'(wbIf.pipe_ready), 32'(p));
    checkOutput({tag, "_lsu_ready"},  32'(wbIf.lsu_ready),  32'(l));
    checkOutput({tag, "_mdu_ready"},  32'(wbIf.mdu_ready),  32'(m));
  endtask

  task automatic checkRf(input string tag, input logic we, input logic [4:0] addr, input logic [31:0] data);
    checkOutput({tag, "_rf_we"},     32'(rfWe),    32'(we));
    checkOutput({tag, "_rf_addr_d"}, 32'(rfAddrD), 32'(addr));
    checkOutput({tag, "_rf_data_d"}, rfDataD,      data);
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    issueValid = 1'b0;
    issueRd    = '0;
    rdAddrA    = '0;
    rdAddrB    = '0;

    // Reset with every requester asserting: nobody may be accepted
    rst_n = 1'b0;
    applyStimulus(1'b1, 5'd1, 32'h1, 1'b1, 5'd2, 32'h2, 1'b1, 5'd3, 32'h3);
    #2;
    checkReady("reset", 1'b0, 1'b0, 1'b0);
    checkRf("reset", 1'b0, 5'd0, 32'h0);
    checkOutput("reset_hazard", 32'(hazardStall), 32'h0);
    nextCycle();
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    rst_n = 1'b1;
    nextCycle();
    checkRf("idle", 1'b0, 5'd0, 32'h0);

    // Single pipeline write
    applyStimulus(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    checkReady("pipe", 1'b1, 1'b0, 1'b0);
    nextCycle();
    checkRf("pipe", 1'b1, 5'd5, 32'hDEADBEEF);
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    checkReady("pipe_idle", 1'b0, 1'b0, 1'b0);
    nextCycle();
    checkRf("pipe_hold", 1'b0, 5'd5, 32'hDEADBEEF);

    // LSU and MDU contending, pipe idle: alternate starting with LSU
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd3, 32'h33, 1'b1, 5'd4, 32'h44);
    for (int i = 0; i < 4; i++) begin
      checkReady($sformatf("rr%0d", i), 1'b0, (i % 2) == 0, (i % 2) == 1);
      nextCycle();
      checkRf($sformatf("rr%0d", i), 1'b1, (i % 2 == 0) ? 5'd3 : 5'd4,
              (i % 2 == 0) ? 32'h33 : 32'h44);
    end

    // Continuous pipe traffic starving LSU: forced through every 5th cycle
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b1, 5'd1, 32'h100 + 32'(i), 1'b1, 5'd9, 32'h99, 1'b0, 5'd0, 32'h0);
      checkReady($sformatf("starve%0d", i), (i % 5) != 4, (i % 5) == 4, 1'b0);
      nextCycle();
      checkRf($sformatf("starve%0d", i), 1'b1, ((i % 5) == 4) ? 5'd9 : 5'd1,
              ((i % 5) == 4) ? 32'h99 : (32'h100 + 32'(i)));
    end

    // MDU write to x0: accepted, no register-file write
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 32'h1234);
    checkReady("x0", 1'b0, 1'b0, 1'b1);
    nextCycle();
    checkRf("x0", 1'b0, 5'd0, 32'h1234);

    // Preferred source (LSU) idle: MDU wins anyway
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd2, 32'h22);
    checkReady("mdu_alone", 1'b0, 1'b0, 1'b1);
    nextCycle();
    checkRf("mdu_alone", 1'b1, 5'd2, 32'h22);
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    nextCycle();

`ifdef AMA_RISCV_RF_SCOREBOARD_EN
    // Issue x7, then watch the stall until the LSU write-back lands
    issueValid = 1'b1; issueRd = 5'd7; rdAddrA = 5'd7; rdAddrB = 5'd0;
    #1;
    checkOutput("sb_before_set", 32'(hazardStall), 32'h0);
    nextCycle();
    issueValid = 1'b0;
    #1;
    checkOutput("sb_pending", 32'(hazardStall), 32'h1);
    nextCycle();
    checkOutput("sb_pending_hold", 32'(hazardStall), 32'h1);
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 32'h77, 1'b0, 5'd0, 32'h0);
    checkReady("sb_clr", 1'b0, 1'b1, 1'b0);
    checkOutput("sb_no_bypass", 32'(hazardStall), 32'h1);
    nextCycle();
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    #1;
    checkOutput("sb_cleared", 32'(hazardStall), 32'h0);
    checkRf("sb_clr", 1'b1, 5'd7, 32'h77);

    // Re-issue x7 in the same cycle as its write-back: set wins
    issueValid = 1'b1; issueRd = 5'd7;
    nextCycle();
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 32'h78);
    checkReady("sb_setclr", 1'b0, 1'b0, 1'b1);
    nextCycle();
    issueValid = 1'b0;
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    #1;
    checkOutput("sb_set_wins", 32'(hazardStall), 32'h1);
    rdAddrA = 5'd0; rdAddrB = 5'd7;
    #1;
    checkOutput("sb_port_b", 32'(hazardStall), 32'h1);
    rdAddrB = 5'd8;
    #1;
    checkOutput("sb_other_reg", 32'(hazardStall), 32'h0);
`else
    // Scoreboard absent: issue traffic must never stall decode
    issueValid = 1'b1; issueRd = 5'd7; rdAddrA = 5'd7; rdAddrB = 5'd7;
    nextCycle();
    issueValid = 1'b0;
    #1;
    checkOutput("nosb_hazard", 32'(hazardStall), 32'h0);
`endif

    // Asynchronous reset clears the output register mid-stream
    applyStimulus(1'b1, 5'd10, 32'hA5A5, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    nextCycle();
    checkRf("pre_reset", 1'b1, 5'd10, 32'hA5A5);
    rst_n = 1'b0;
    #1;
    checkRf("async_reset", 1'b0, 5'd0, 32'h0);
    checkReady("async_reset", 1'b0, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
